// File: rtl/box_overlay.sv
// Draws up to N_BOX rectangular outlines over an RGB565 video stream with a 2-cycle pipeline.
// Define BOX_OVERLAY_COLOR_EN for per-box border colours; otherwise every box is drawn red.
module box_overlay #(
    parameter int N_BOX       = 4,
    parameter int H_BOX_WIDTH = 2,
    parameter int V_BOX_WIDTH = 2,
    parameter int H_ACT       = 1280,
    parameter int V_ACT       = 720,
    localparam int IW         = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vsync,
    input  logic          in_hsync,
    input  logic          in_de,
    input  logic [15:0]   in_pix,
    input  logic          box_wr_valid,
    output logic          box_wr_ready,
    input  logic [IW-1:0] box_wr_idx,
    input  logic          box_wr_en,
    input  logic [47:0]   box_wr_rect,
`ifdef BOX_OVERLAY_COLOR_EN
    input  logic [15:0]   box_wr_color,
`endif
    output logic          out_vsync,
    output logic          out_hsync,
    output logic          out_de,
    output logic [15:0]   out_pix,
    output logic          idx_err
);

    localparam logic [15:0] BOX_RED = 16'hF800;

    logic        vs_prev, de_prev, commit;
    logic [11:0] x, y;
    logic        vs_rise, wr_fire, idx_ok, in_area;

    logic        sh_en    [N_BOX];
    logic        act_en   [N_BOX];
    logic [47:0] sh_rect  [N_BOX];
    logic [47:0] act_rect [N_BOX];
`ifdef BOX_OVERLAY_COLOR_EN
    logic [15:0] sh_color  [N_BOX];
    logic [15:0] act_color [N_BOX];
`endif

    logic [N_BOX-1:0] hit, s1_hit;
    logic             s1_vs, s1_hs, s1_de;
    logic [15:0]      s1_pix;
    logic             sel_any;
    logic [15:0]      sel_color;

    assign vs_rise      = in_vsync & ~vs_prev;
    assign box_wr_ready = ~rst & ~commit;
    assign wr_fire      = box_wr_valid & box_wr_ready;
    assign idx_ok       = {1'b0, box_wr_idx} < (IW+1)'(N_BOX);
    assign in_area      = ({1'b0, x} < 13'(H_ACT)) && ({1'b0, y} < 13'(V_ACT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev <= 1'b0;
            de_prev <= 1'b0;
            commit  <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else begin
            vs_prev <= in_vsync;
            de_prev <= in_de;
            commit  <= vs_rise;
            if (vs_rise) begin
                x <= '0;
                y <= '0;
            end else if (de_prev && !in_de) begin
                x <= '0;
                y <= y + 12'd1;
            end else if (in_de) begin
                x <= x + 12'd1;
            end
        end
    end

    // Only the enable bits are reset; a cleared enable makes stale geometry harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_err <= 1'b0;
            for (int unsigned i = 0; i < N_BOX; i++) begin
                sh_en[i]  <= 1'b0;
                act_en[i] <= 1'b0;
            end
        end else begin
            idx_err <= wr_fire && !idx_ok;
            if (wr_fire && idx_ok)
                sh_en[box_wr_idx] <= box_wr_en;
            if (commit)
                for (int unsigned i = 0; i < N_BOX; i++)
                    act_en[i] <= sh_en[i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && idx_ok) begin
            sh_rect[box_wr_idx] <= box_wr_rect;
`ifdef BOX_OVERLAY_COLOR_EN
            sh_color[box_wr_idx] <= box_wr_color;
`endif
        end
        if (commit) begin
            for (int unsigned i = 0; i < N_BOX; i++) begin
                act_rect[i] <= sh_rect[i];
`ifdef BOX_OVERLAY_COLOR_EN
                act_color[i] <= sh_color[i];
`endif
            end
        end
    end

    // Widened to 13 bits so x+width near 4095 cannot wrap.
    function automatic logic box_hit(input logic en, input logic [47:0] r,
                                     input logic [11:0] px, input logic [11:0] py);
        logic [12:0] x0, y0, x1, y1, xx, yy;
        x0 = {1'b0, r[47:36]};
        y0 = {1'b0, r[35:24]};
        x1 = {1'b0, r[23:12]};
        y1 = {1'b0, r[11:0]};
        xx = {1'b0, px};
        yy = {1'b0, py};
        return en && (x0 <= x1) && (y0 <= y1) &&
               (x0 <= xx) && (xx <= x1) && (y0 <= yy) && (yy <= y1) &&
               ((xx < x0 + 13'(H_BOX_WIDTH)) || (xx + 13'(H_BOX_WIDTH) > x1) ||
                (yy < y0 + 13'(V_BOX_WIDTH)) || (yy + 13'(V_BOX_WIDTH) > y1));
    endfunction

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N_BOX; i++)
            hit[i] = box_hit(act_en[i], act_rect[i], x, y);
    end

    always_comb begin
        sel_any   = 1'b0;
        sel_color = BOX_RED;
        for (int unsigned i = 0; i < N_BOX; i++) begin
            if (!sel_any && s1_hit[i]) begin
                sel_any = 1'b1;
`ifdef BOX_OVERLAY_COLOR_EN
                sel_color = act_color[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vs     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_pix    <= '0;
            s1_hit    <= '0;
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_de    <= 1'b0;
            out_pix   <= '0;
        end else begin
            s1_vs     <= in_vsync;
            s1_hs     <= in_hsync;
            s1_de     <= in_de;
            s1_pix    <= in_pix;
            s1_hit    <= (in_de && in_area) ? hit : '0;
            out_vsync <= s1_vs;
            out_hsync <= s1_hs;
            out_de    <= s1_de;
            out_pix   <= sel_any ? sel_color : s1_pix;
        end
    end

endmodule

// File: tb/tb_box_overlay.sv
// Scoreboard bench for box_overlay: driver pushes expected pixels, a negedge monitor pops on out_de.
// Builds with or without BOX_OVERLAY_COLOR_EN.
module tb_box_overlay;

    localparam int NB = 3;
    localparam int HA = 220;
    localparam int VA = 400;
    localparam int HW = 2;
    localparam int VW = 2;
`ifdef BOX_OVERLAY_COLOR_EN
    localparam logic [15:0] C0 = 16'h07E0, C1 = 16'h001F, C2 = 16'hFFE0;
`else
    localparam logic [15:0] C0 = 16'hF800, C1 = 16'hF800, C2 = 16'hF800;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_vsync = 1'b0, in_hsync = 1'b0, in_de = 1'b0;
    logic [15:0] in_pix = '0;
    logic        box_wr_valid = 1'b0, box_wr_ready;
    logic [1:0]  box_wr_idx = '0;
    logic        box_wr_en = 1'b0;
    logic [47:0] box_wr_rect = '0;
`ifdef BOX_OVERLAY_COLOR_EN
    logic [15:0] box_wr_color = '0;
`endif
    logic        out_vsync, out_hsync, out_de, idx_err;
    logic [15:0] out_pix;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_y    = 0;

    typedef struct {
        logic [15:0] pix;
        int          x;
        int          y;
    } exp_t;
    exp_t exp_q[$];

    bit          m_sh_en   [NB];
    bit          m_act_en  [NB];
    logic [47:0] m_sh_rect [NB];
    logic [47:0] m_act_rect[NB];
    logic [15:0] m_sh_col  [NB];
    logic [15:0] m_act_col [NB];

    always #5 clk = ~clk;

    box_overlay #(
        .N_BOX(NB), .H_BOX_WIDTH(HW), .V_BOX_WIDTH(VW), .H_ACT(HA), .V_ACT(VA)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .in_pix(in_pix),
        .box_wr_valid(box_wr_valid), .box_wr_ready(box_wr_ready),
        .box_wr_idx(box_wr_idx), .box_wr_en(box_wr_en), .box_wr_rect(box_wr_rect),
`ifdef BOX_OVERLAY_COLOR_EN
        .box_wr_color(box_wr_color),
`endif
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
        .out_pix(out_pix), .idx_err(idx_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [47:0] rect(input int x0, input int y0, input int x1, input int y1);
        return {12'(x0), 12'(y0), 12'(x1), 12'(y1)};
    endfunction

    function automatic logic [15:0] pixval(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {4'h1, xv[5:0], yv[5:0]};
    endfunction

    // Reference: inside the rect and within HW/VW of any side, lowest index first.
    function automatic logic [15:0] exp_pix(input int x, input int y, input logic [15:0] p);
        for (int i = 0; i < NB; i++) begin
            int x0, y0, x1, y1;
            x0 = int'(m_act_rect[i][47:36]);
            y0 = int'(m_act_rect[i][35:24]);
            x1 = int'(m_act_rect[i][23:12]);
            y1 = int'(m_act_rect[i][11:0]);
            if (m_act_en[i] && x0 <= x1 && y0 <= y1 && x >= x0 && x <= x1 && y >= y0 && y <= y1 &&
                x < HA && y < VA &&
                (x < x0 + HW || x > x1 - HW || y < y0 + VW || y > y1 - VW))
                return m_act_col[i];
        end
        return p;
    endfunction

    function automatic bit full_line(input int y);
        return (y >= 48 && y <= 53) || (y >= 58 && y <= 62) || (y >= 86 && y <= 92) ||
               (y >= 98 && y <= 102) || (y >= 138 && y <= 151);
    endfunction

    always @(negedge clk) begin
        if (out_de === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_de: out_de=1 with empty scoreboard, out_pix=%0h", out_pix);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("pix(%0d,%0d)", e.x, e.y), {16'h0, out_pix}, {16'h0, e.pix});
                check("sync_during_de", {30'h0, out_hsync, out_vsync}, 32'h0);
            end
        end
    end

    task automatic drive_pixel(input int x);
        @(negedge clk);
        in_de    = 1'b1;
        in_hsync = 1'b0;
        in_pix   = pixval(x, cur_y);
        exp_q.push_back('{exp_pix(x, cur_y, in_pix), x, cur_y});
    endtask

    task automatic drive_line(input int npix);
        for (int x = 0; x < npix; x++) drive_pixel(x);
        @(negedge clk);
        in_de    = 1'b0;
        in_hsync = 1'b1;
        @(negedge clk);
        in_hsync = 1'b0;
        @(negedge clk);
        check("hsync_delay", {31'h0, out_hsync}, 32'h1);
        cur_y++;
    endtask

    task automatic drive_lines(input int n);
        for (int l = 0; l < n; l++) drive_line(full_line(cur_y) ? HA : 1);
    endtask

    task automatic set_wr(input int idx, input bit en, input logic [47:0] r, input logic [15:0] c);
        logic [31:0] iv;
        iv = idx;
        box_wr_valid = 1'b1;
        box_wr_idx   = iv[1:0];
        box_wr_en    = en;
        box_wr_rect  = r;
`ifdef BOX_OVERLAY_COLOR_EN
        box_wr_color = c;
`endif
        if (idx < NB) begin
            m_sh_en[idx]   = en;
            m_sh_rect[idx] = r;
            m_sh_col[idx]  = c;
        end
    endtask

    task automatic box_write(input int idx, input bit en, input logic [47:0] r, input logic [15:0] c);
        int waitn = 0;
        @(negedge clk);
        while (box_wr_ready !== 1'b1 && waitn < 8) begin
            @(negedge clk);
            waitn++;
        end
        if (box_wr_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: box_wr_ready=%b after %0d cycles, expected 1", box_wr_ready, waitn);
            return;
        end
        check("idx_err_idle", {31'h0, idx_err}, 32'h0);
        set_wr(idx, en, r, c);
        @(negedge clk);
        box_wr_valid = 1'b0;
        check("idx_err_pulse", {31'h0, idx_err}, (idx >= NB) ? 32'h1 : 32'h0);
        @(negedge clk);
        check("idx_err_clear", {31'h0, idx_err}, 32'h0);
    endtask

    // Optionally raises a write during the commit cycle; the source holds it until accepted.
    task automatic do_vsync(input bit cw, input int idx, input bit en, input logic [47:0] r,
                            input logic [15:0] c);
        @(negedge clk);
        in_vsync = 1'b1;
        check("ready_before_commit", {31'h0, box_wr_ready}, 32'h1);
        @(negedge clk);
        check("ready_commit_cycle", {31'h0, box_wr_ready}, 32'h0);
        check("vsync_delay1", {31'h0, out_vsync}, 32'h0);
        m_act_en   = m_sh_en;
        m_act_rect = m_sh_rect;
        m_act_col  = m_sh_col;
        if (cw) set_wr(idx, en, r, c);
        @(negedge clk);
        check("vsync_delay2", {31'h0, out_vsync}, 32'h1);
        check("ready_after_commit", {31'h0, box_wr_ready}, 32'h1);
        @(negedge clk);
        box_wr_valid = 1'b0;
        in_vsync     = 1'b0;
        repeat (2) @(negedge clk);
        cur_y = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_sh_en[i]  = 1'b0;
            m_act_en[i] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < NB; i++) begin
            m_sh_rect[i]  = '0;
            m_act_rect[i] = '0;
            m_sh_col[i]   = '0;
            m_act_col[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_out_vsync", {31'h0, out_vsync}, 32'h0);
        check("rst_out_hsync", {31'h0, out_hsync}, 32'h0);
        check("rst_out_de", {31'h0, out_de}, 32'h0);
        check("rst_out_pix", {16'h0, out_pix}, 32'h0);
        check("rst_idx_err", {31'h0, idx_err}, 32'h0);
        check("rst_ready", {31'h0, box_wr_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'h0, box_wr_ready}, 32'h1);

        // Frame 0: nothing active; writes mid-frame must not show yet.
        do_vsync(1'b0, 0, 1'b0, '0, '0);
        drive_lines(100);
        box_write(0, 1'b1, rect(100, 50, 199, 149), C0);
        box_write(1, 1'b1, rect(300, 50, 200, 149), C1);
        box_write(2, 1'b1, rect(200, 140, 4000, 4000), C2);
        box_write(3, 1'b1, rect(0, 0, 219, 151), C0);
        drive_lines(52);

        // Frame 1: box0 and clipped box2 drawn, inverted box1 not; write held through commit.
        do_vsync(1'b1, 1, 1'b1, rect(120, 60, 140, 80), C1);
        drive_lines(152);

        // Frame 2: box1 from the held write appears; two box0 writes, later wins; box2 disabled.
        do_vsync(1'b0, 0, 1'b0, '0, '0);
        drive_lines(100);
        box_write(0, 1'b1, rect(10, 10, 20, 20), C0);
        box_write(0, 1'b1, rect(120, 60, 180, 90), C0);
        box_write(2, 1'b0, rect(200, 140, 4000, 4000), C2);
        drive_lines(52);

        // Frame 3: boxes 0 and 1 share corner (120,60); box0 takes priority.
        do_vsync(1'b0, 0, 1'b0, '0, '0);
        drive_lines(152);

        // Frame 4: reset in the middle of line 360.
        do_vsync(1'b0, 0, 1'b0, '0, '0);
        drive_lines(360);
        for (int x = 0; x < 50; x++) drive_pixel(x);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("midrst_out_vsync", {31'h0, out_vsync}, 32'h0);
        check("midrst_out_hsync", {31'h0, out_hsync}, 32'h0);
        check("midrst_out_de", {31'h0, out_de}, 32'h0);
        check("midrst_out_pix", {16'h0, out_pix}, 32'h0);
        check("midrst_ready", {31'h0, box_wr_ready}, 32'h0);
        @(negedge clk);
        in_de = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        cur_y = 0;
        @(negedge clk);
        check("ready_after_midrst", {31'h0, box_wr_ready}, 32'h1);
        drive_lines(152);

        // Frame 5: commit of cleared shadows keeps everything off.
        do_vsync(1'b0, 0, 1'b0, '0, '0);
        drive_lines(100);
        box_write(0, 1'b1, rect(100, 50, 199, 149), C0);
        drive_lines(52);

        // Frame 6: drawing resumes one commit after the reset.
        do_vsync(1'b0, 0, 1'b0, '0, '0);
        drive_lines(152);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
